// File: rtl/delay_pkg.sv
// Shared types and constants for the delay measurement block and its
// companion delay element model.
package delay_pkg;

  localparam int CW_DEF = 32;
  localparam int DW_DEF = 16;

  localparam logic [CW_DEF-1:0] CNT_MAX = {CW_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/delay_measure_if.sv
// Result channel of the delay measurement block.
// valid/ready: a result transfers on every cycle where valid && ready are both
// high at the rising clock edge; once valid rises, delay and timed_out stay
// stable and valid stays high until that transfer happens.
interface delay_measure_if #(
  parameter int CW = 32
);
  logic [CW-1:0] delay;
  logic          timed_out;
  logic          valid;
  logic          ready;

  modport master (
    output delay,
    output timed_out,
    output valid,
    input  ready
  );

  modport slave (
    input  delay,
    input  timed_out,
    input  valid,
    output ready
  );
endinterface

// File: rtl/edge_sampler.sv
// Registers the stimulus and response levels and flags a change between two
// consecutive samples; both paths share the same latency.
module edge_sampler (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic out,
  output logic in_lvl,
  output logic out_lvl,
  output logic in_edge,
  output logic out_edge
);

  logic in_prev;
  logic out_prev;

  // Previous samples reset to 0, so a high level right after reset is an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_lvl   <= 1'b0;
      out_lvl  <= 1'b0;
      in_prev  <= 1'b0;
      out_prev <= 1'b0;
    end else begin
      in_lvl   <= in;
      out_lvl  <= out;
      in_prev  <= in_lvl;
      out_prev <= out_lvl;
    end
  end

  assign in_edge  = in_lvl ^ in_prev;
  assign out_edge = out_lvl ^ out_prev;

endmodule

// File: rtl/delay_measure.sv
// Measures, in clock cycles, how long a stimulus transition takes to appear at
// the output of a delay element, with timeout and dropped-edge accounting.
module delay_measure
  import delay_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in,
  input  logic          out,
  input  logic [CW-1:0] timeout,
  output logic          busy,
  output logic [DW-1:0] dropped,
  output state_t        state_dbg,
  delay_measure_if.master res
);

  localparam logic [CW-1:0] CNT_ALL = {CW{1'b1}};

  logic in_lvl, out_lvl, in_edge, out_edge;

  edge_sampler u_sampler (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .out      (out),
    .in_lvl   (in_lvl),
    .out_lvl  (out_lvl),
    .in_edge  (in_edge),
    .out_edge (out_edge)
  );

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic          target, target_n;
  logic [CW-1:0] delay_r, delay_n;
  logic          to_r, to_n;
  logic [DW-1:0] dropped_r;
  logic          drop_inc;
  logic          match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      target    <= 1'b0;
      delay_r   <= '0;
      to_r      <= 1'b0;
      dropped_r <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      target  <= target_n;
      delay_r <= delay_n;
      to_r    <= to_n;
      if (drop_inc && (dropped_r != {DW{1'b1}}))
        dropped_r <= dropped_r + DW'(1);
    end
  end

  assign match = out_edge && (out_lvl == target);

  always_comb begin
    state_n  = state;
    count_n  = count;
    target_n = target;
    delay_n  = delay_r;
    to_n     = to_r;
    drop_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && in_edge) begin
          target_n = in_lvl;
          if (out_edge && (out_lvl == in_lvl)) begin
            state_n = REPORT;
            delay_n = '0;
            to_n    = 1'b0;
          end else begin
            state_n = COUNT;
            count_n = CW'(1);
          end
        end
      end
      COUNT: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          drop_inc = in_edge;
          // A match is checked first so it wins over a timeout in the same cycle.
          if (match) begin
            state_n = REPORT;
            delay_n = count;
            to_n    = 1'b0;
          end else if ((timeout != '0) && (count == timeout)) begin
            state_n = REPORT;
            delay_n = timeout;
            to_n    = 1'b1;
          end else if (count != CNT_ALL) begin
            count_n = count + CW'(1);
          end
        end
      end
      REPORT: begin
        drop_inc = in_edge;
        if (res.ready)
          state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy          = (state == COUNT);
  assign dropped       = dropped_r;
  assign state_dbg     = state;
  assign res.valid     = (state == REPORT);
  assign res.delay     = delay_r;
  assign res.timed_out = to_r;

endmodule

// File: tb/tb_delay_measure.sv
// Scenario bench for delay_measure: a result scoreboard on the main instance
// plus a narrow-counter instance for the saturation case.
module tb_delay_measure;
  import delay_pkg::*;

  localparam int CW = 32;
  localparam int DW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          en;
  logic          in_s, out_s;
  logic [CW-1:0] timeout;
  logic          busy;
  logic [DW-1:0] dropped;
  state_t        state_dbg;

  delay_measure_if #(.CW(CW)) rif ();

  delay_measure #(.CW(CW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in_s),
    .out       (out_s),
    .timeout   (timeout),
    .busy      (busy),
    .dropped   (dropped),
    .state_dbg (state_dbg),
    .res       (rif.master)
  );

  logic          in2, out2;
  logic [3:0]    timeout2;
  logic          busy2;
  logic [DW-1:0] dropped2;
  state_t        state2;

  delay_measure_if #(.CW(4)) rif2 ();

  delay_measure #(.CW(4), .DW(DW)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in2),
    .out       (out2),
    .timeout   (timeout2),
    .busy      (busy2),
    .dropped   (dropped2),
    .state_dbg (state2),
    .res       (rif2.master)
  );

  int            vectors = 0;
  int            errors  = 0;
  int            exp_dropped = 0;
  logic [CW:0]   exp_q[$];
  logic [CW:0]   exp_e;
  logic          hold_v = 1'b0;
  logic [CW:0]   hold_val;

  // scoreboard: pops on each handshake, and checks the result holds while stalled
  always begin
    @(posedge clk);
    #3;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && rif.valid) begin
        vectors++;
        if ({rif.timed_out, rif.delay} !== hold_val) begin
          errors++;
          $display("FAIL hold_stable: got %h want %h", {rif.timed_out, rif.delay}, hold_val);
        end
      end
      if (rif.valid && rif.ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got to=%0b delay=%0d with empty queue", rif.timed_out, rif.delay);
        end else begin
          exp_e = exp_q.pop_front();
          if ({rif.timed_out, rif.delay} !== exp_e) begin
            errors++;
            $display("FAIL result: got to=%0b delay=%0d want to=%0b delay=%0d",
                     rif.timed_out, rif.delay, exp_e[CW], exp_e[CW-1:0]);
          end
        end
        hold_v = 1'b0;
      end else if (rif.valid) begin
        hold_v   = 1'b1;
        hold_val = {rif.timed_out, rif.delay};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!rif.valid && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (!rif.valid) begin
      errors++;
      $display("FAIL wait_valid: valid=0 after %0d cycles, want 1", budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding after %0d cycles, want 0", exp_q.size(), budget);
    end
    steps(2);
  endtask

  task automatic do_measure(input int d, input logic [CW-1:0] t);
    step();
    timeout = t;
    in_s = ~in_s;
    if (t != '0 && d > int'(t)) exp_q.push_back({1'b1, t});
    else                        exp_q.push_back({1'b0, CW'(d)});
    if (d > 0) steps(d);
    out_s = in_s;
    wait_drain(d + int'(t) + 40);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; in_s = 1'b0; out_s = 1'b0; timeout = '0;
    rif.ready = 1'b0; in2 = 1'b0; out2 = 1'b0; timeout2 = '0; rif2.ready = 1'b1;
    steps(3);
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", rif.valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (dropped !== '0) begin errors++; $display("FAIL rst_dropped: got %0d want 0", dropped); end
    vectors++; if (rif.delay !== '0 || rif.timed_out !== 1'b0) begin errors++; $display("FAIL rst_result: got to=%b delay=%0d want 0/0", rif.timed_out, rif.delay); end
    vectors++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", state_dbg); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    en = 1'b1; rif.ready = 1'b0; timeout = '0;
    step();
    in_s = ~in_s;
    exp_q.push_back({1'b0, CW'(5)});
    steps(5);
    out_s = in_s;
    wait_valid(10);
    vectors++; if (rif.delay !== CW'(5)) begin errors++; $display("FAIL basic_delay: got %0d want 5", rif.delay); end
    steps(3);
    vectors++; if (rif.valid !== 1'b1) begin errors++; $display("FAIL basic_hold: valid got %b want 1", rif.valid); end
    rif.ready = 1'b1;
    step();
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL basic_clear: valid got %b want 0", rif.valid); end
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_pop: queue %0d want 0", exp_q.size()); end
  endtask

  task automatic test_zero_latency();
    rif.ready = 1'b1;
    step();
    in_s = ~in_s;
    out_s = in_s;
    exp_q.push_back({1'b0, CW'(0)});
    step();
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL zero_early: valid got %b want 0", rif.valid); end
    step();
    vectors++; if (rif.valid !== 1'b1) begin errors++; $display("FAIL zero_latency: valid got %b want 1", rif.valid); end
    step();
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL zero_clear: valid got %b want 0", rif.valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    rif.ready = 1'b0;
    timeout = CW'(8);
    step();
    in_s = ~in_s;
    exp_q.push_back({1'b1, CW'(8)});
    wait_valid(20);
    vectors++; if (rif.timed_out !== 1'b1 || rif.delay !== CW'(8)) begin errors++; $display("FAIL timeout_result: got to=%b delay=%0d want 1/8", rif.timed_out, rif.delay); end
    rif.ready = 1'b1;
    wait_drain(10);
    out_s = in_s;
    steps(3);
    vectors++; if (state_dbg !== IDLE || rif.valid !== 1'b0) begin errors++; $display("FAIL timeout_idle: state=%0d valid=%b want IDLE/0", state_dbg, rif.valid); end
    do_measure(8, CW'(8));
  endtask

  task automatic test_dropped();
    logic tgt;
    rif.ready = 1'b0;
    timeout = '0;
    step();
    in_s = ~in_s;
    tgt = in_s;
    exp_q.push_back({1'b0, CW'(6)});
    steps(2);
    in_s = ~in_s;
    exp_dropped++;
    steps(4);
    out_s = tgt;
    wait_valid(10);
    vectors++; if (dropped !== DW'(exp_dropped)) begin errors++; $display("FAIL drop_count: got %0d want %0d", dropped, exp_dropped); end
    in_s = ~in_s;
    steps(2);
    in_s = ~in_s;
    steps(3);
    exp_dropped += 2;
    vectors++; if (dropped !== DW'(exp_dropped)) begin errors++; $display("FAIL drop_report: got %0d want %0d", dropped, exp_dropped); end
    vectors++; if (rif.valid !== 1'b1 || rif.delay !== CW'(6)) begin errors++; $display("FAIL drop_hold: valid=%b delay=%0d want 1/6", rif.valid, rif.delay); end
    rif.ready = 1'b1;
    steps(2);
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL drop_clear: valid got %b want 0", rif.valid); end
    out_s = in_s;
    steps(3);
    vectors++; if (dropped !== DW'(exp_dropped)) begin errors++; $display("FAIL drop_idle: got %0d want %0d", dropped, exp_dropped); end
  endtask

  task automatic test_abort();
    rif.ready = 1'b1;
    timeout = '0;
    step();
    in_s = ~in_s;
    steps(4);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", busy); end
    en = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b want 0", busy); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL abort_novalid: valid got %b want 0", rif.valid); end
    end
    in_s = out_s;
    steps(3);
    vectors++; if (dropped !== DW'(exp_dropped)) begin errors++; $display("FAIL abort_dropped: got %0d want %0d", dropped, exp_dropped); end
    en = 1'b1;
  endtask

  task automatic test_reset_report();
    rif.ready = 1'b0;
    step();
    in_s = ~in_s;
    out_s = in_s;
    wait_valid(10);
    reset = 1'b1;
    in_s = 1'b0;
    out_s = 1'b0;
    step();
    vectors++; if (rif.valid !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b want 0", rif.valid); end
    vectors++; if (dropped !== '0) begin errors++; $display("FAIL rr_dropped: got %0d want 0", dropped); end
    vectors++; if (rif.delay !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rr_outputs: delay=%0d busy=%b want 0/0", rif.delay, busy); end
    reset = 1'b0;
    exp_dropped = 0;
    steps(2);
    vectors++; if (state_dbg !== IDLE || rif.valid !== 1'b0) begin errors++; $display("FAIL rr_idle: state=%0d valid=%b want IDLE/0", state_dbg, rif.valid); end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [CW-1:0] t;
    rif.ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 12);
      t = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(3, 10)) : '0;
      do_measure(d, t);
    end
    vectors++; if (dropped !== DW'(exp_dropped)) begin errors++; $display("FAIL b2b_dropped: got %0d want %0d", dropped, exp_dropped); end
  endtask

  task automatic test_saturate();
    int n = 0;
    rif2.ready = 1'b1;
    timeout2 = '0;
    step();
    in2 = ~in2;
    steps(25);
    vectors++; if (busy2 !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b want 1", busy2); end
    out2 = in2;
    while (!rif2.valid && n < 10) begin
      step();
      n++;
    end
    vectors++; if (rif2.valid !== 1'b1 || rif2.delay !== 4'd15 || rif2.timed_out !== 1'b0) begin
      errors++; $display("FAIL sat_delay: valid=%b delay=%0d to=%b want 1/15/0", rif2.valid, rif2.delay, rif2.timed_out);
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_latency();
    test_timeout();
    test_dropped();
    test_abort();
    test_reset_report();
    test_back_to_back();
    test_saturate();
    vectors++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d outstanding want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
